// File: rtl/commit_trace_fifo.sv
// Commit-trace capture: stamps RF/DM architectural writes with PC and timestamp
// and buffers them in a first-word-fall-through FIFO drained over valid/ready.
module commit_trace_fifo #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 16,
   parameter int TS_W      = 16,
   parameter int OVERWRITE = 0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_clr,
   input  logic [XLEN-1:0]            i_pc,
   input  logic                       i_rf_wen,
   input  logic [4:0]                 i_rf_wnum,
   input  logic [XLEN-1:0]            i_rf_wd,
   input  logic                       i_dm_wen,
   input  logic [XLEN-1:0]            i_dm_addr,
   input  logic [XLEN-1:0]            i_dm_wd,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [1:0]                 o_kind,
   output logic [XLEN-1:0]            o_pc,
   output logic [XLEN-1:0]            o_dst,
   output logic [XLEN-1:0]            o_data,
   output logic [TS_W-1:0]            o_ts,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_ovf,
   output logic                       o_collision
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d, col_q, col_d;
   logic [TS_W-1:0] ts_q, ts_d;

   logic [1:0]      kind_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [XLEN-1:0] dst_mem  [DEPTH];
   logic [XLEN-1:0] data_mem [DEPTH];
   logic [TS_W-1:0] ts_mem   [DEPTH];

   logic            rf_hit, dm_hit, push, pop, full, empty, wr_en;
   logic [1:0]      e_kind;
   logic [XLEN-1:0] e_dst, e_data;

   assign rf_hit = i_en & i_rf_wen & (i_rf_wnum != 5'd0);
   assign dm_hit = i_en & i_dm_wen;
   assign push   = rf_hit | dm_hit;
   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign pop    = ~empty & i_ready;

   // RF wins when both ports write in the same cycle; the DM write is lost
   assign e_kind = rf_hit ? 2'b01 : 2'b10;
   assign e_dst  = rf_hit ? {{(XLEN-5){1'b0}}, i_rf_wnum} : i_dm_addr;
   assign e_data = rf_hit ? i_rf_wd : i_dm_wd;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      col_d    = col_q;
      ts_d     = ts_q;
      wr_en    = 1'b0;
      if (push) begin
         if (pop) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
         end else begin
            ovf_d = 1'b1;
            // when full wr_ptr == rd_ptr, so this replaces the oldest entry
            if (OVERWRITE != 0) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
               rd_ptr_d = rd_ptr_q + AW'(1);
            end
         end
      end else if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         count_d  = count_q - CW'(1);
      end
      if (rf_hit & dm_hit) col_d = 1'b1;
      if (i_en) ts_d = ts_q + TS_W'(1);
      if (i_clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         col_d    = 1'b0;
         ts_d     = '0;
         wr_en    = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         col_q    <= 1'b0;
         ts_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         col_q    <= col_d;
         ts_q     <= ts_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en && !i_rst) begin
         kind_mem[wr_ptr_q] <= e_kind;
         pc_mem[wr_ptr_q]   <= i_pc;
         dst_mem[wr_ptr_q]  <= e_dst;
         data_mem[wr_ptr_q] <= e_data;
         ts_mem[wr_ptr_q]   <= ts_q;
      end
   end

   assign o_valid     = ~empty;
   assign o_kind      = empty ? '0 : kind_mem[rd_ptr_q];
   assign o_pc        = empty ? '0 : pc_mem[rd_ptr_q];
   assign o_dst       = empty ? '0 : dst_mem[rd_ptr_q];
   assign o_data      = empty ? '0 : data_mem[rd_ptr_q];
   assign o_ts        = empty ? '0 : ts_mem[rd_ptr_q];
   assign o_count     = count_q;
   assign o_ovf       = ovf_q;
   assign o_collision = col_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: drop (inst 0) and overwrite (inst 1) variants
// share stimulus and are checked against a shift-array queue model.
module tb_commit_trace_fifo;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] pc;
      logic [31:0] dst;
      logic [31:0] data;
      logic [15:0] ts;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, en, clr, rf_wen, dm_wen, ready;
   logic [4:0]  wnum;
   logic [31:0] pc, rf_wd, dm_addr, dm_wd;

   logic [1:0]  ov, okind [2], oovf, ocol;
   logic [31:0] opc [2], odst [2], odata [2];
   logic [15:0] ots [2];
   logic [4:0]  ocnt [2];

   int n_cmp = 0;
   int n_err = 0;

   ent_t        mq [2][DEPTH];
   int          mn [2];
   bit          movf [2];
   bit          mcol;
   logic [15:0] mts;

   always #5 clk = ~clk;

   commit_trace_fifo #(.XLEN(32), .DEPTH(DEPTH), .TS_W(16), .OVERWRITE(0)) u0 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_pc(pc),
      .i_rf_wen(rf_wen), .i_rf_wnum(wnum), .i_rf_wd(rf_wd),
      .i_dm_wen(dm_wen), .i_dm_addr(dm_addr), .i_dm_wd(dm_wd),
      .o_valid(ov[0]), .i_ready(ready), .o_kind(okind[0]), .o_pc(opc[0]),
      .o_dst(odst[0]), .o_data(odata[0]), .o_ts(ots[0]), .o_count(ocnt[0]),
      .o_ovf(oovf[0]), .o_collision(ocol[0]));

   commit_trace_fifo #(.XLEN(32), .DEPTH(DEPTH), .TS_W(16), .OVERWRITE(1)) u1 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_pc(pc),
      .i_rf_wen(rf_wen), .i_rf_wnum(wnum), .i_rf_wd(rf_wd),
      .i_dm_wen(dm_wen), .i_dm_addr(dm_addr), .i_dm_wd(dm_wd),
      .o_valid(ov[1]), .i_ready(ready), .o_kind(okind[1]), .o_pc(opc[1]),
      .o_dst(odst[1]), .o_data(odata[1]), .o_ts(ots[1]), .o_count(ocnt[1]),
      .o_ovf(oovf[1]), .o_collision(ocol[1]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_pop(input int i);
      for (int j = 0; j < DEPTH-1; j++) mq[i][j] = mq[i][j+1];
      mn[i]--;
   endtask

   task automatic model_step();
      bit   rf_hit, dm_hit, do_pop;
      ent_t e;
      rf_hit = en && rf_wen && (wnum != 5'd0);
      dm_hit = en && dm_wen;
      e.kind = rf_hit ? 2'b01 : 2'b10;
      e.pc   = pc;
      e.dst  = rf_hit ? {27'd0, wnum} : dm_addr;
      e.data = rf_hit ? rf_wd : dm_wd;
      e.ts   = mts;
      if (rst || clr) begin
         for (int i = 0; i < 2; i++) begin
            mn[i]   = 0;
            movf[i] = 0;
         end
         mcol = 0;
         mts  = '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            do_pop = (mn[i] > 0) && ready;
            if (do_pop) model_pop(i);
            if (rf_hit || dm_hit) begin
               if (mn[i] == DEPTH) begin
                  movf[i] = 1;
                  if (i == 1) model_pop(i);
               end
               if (mn[i] < DEPTH) begin
                  mq[i][mn[i]] = e;
                  mn[i]++;
               end
            end
         end
         if (rf_hit && dm_hit) mcol = 1;
         if (en) mts = mts + 16'd1;
      end
   endtask

   task automatic check_all();
      ent_t h;
      for (int i = 0; i < 2; i++) begin
         h = (mn[i] > 0) ? mq[i][0] : '0;
         chk($sformatf("valid%0d", i), ov[i], (mn[i] > 0));
         chk($sformatf("count%0d", i), ocnt[i], mn[i]);
         chk($sformatf("kind%0d", i), okind[i], h.kind);
         chk($sformatf("pc%0d", i), opc[i], h.pc);
         chk($sformatf("dst%0d", i), odst[i], h.dst);
         chk($sformatf("data%0d", i), odata[i], h.data);
         chk($sformatf("ts%0d", i), ots[i], h.ts);
         chk($sformatf("ovf%0d", i), oovf[i], movf[i]);
         chk($sformatf("col%0d", i), ocol[i], mcol);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      rst = 0; clr = 0; en = 1; rf_wen = 0; dm_wen = 0; ready = 0;
      wnum = '0; pc = '0; rf_wd = '0; dm_addr = '0; dm_wd = '0;
   endtask

   task automatic set_rf(input logic [4:0] n, input logic [31:0] d);
      idle();
      rf_wen = 1; wnum = n; rf_wd = d; pc = 32'h1000 + d;
   endtask

   initial begin
      int rp;
      idle();
      rst = 1;
      tick();
      tick();
      chk("rst_valid", ov[0], 0);
      chk("rst_count", ocnt[0], 0);

      // capture of one RF write
      set_rf(5'd5, 32'hDEAD_BEEF);
      pc = 32'h100;
      tick();
      chk("t1_valid", ov[0], 1);
      chk("t1_kind", okind[0], 2'b01);
      chk("t1_dst", odst[0], 5);
      chk("t1_data", odata[0], 32'hDEAD_BEEF);
      chk("t1_pc", opc[0], 32'h100);
      chk("t1_count", ocnt[0], 1);

      // x0 write ignored; DM write captured
      idle(); clr = 1; tick();
      set_rf(5'd0, 32'h1234); tick();
      chk("x0_count", ocnt[0], 0);
      idle(); dm_wen = 1; dm_addr = 32'h2000; dm_wd = 32'h55; tick();
      chk("dm_kind", okind[0], 2'b10);
      chk("dm_dst", odst[0], 32'h2000);

      // 17 pushes into 16 slots, then drain
      idle(); clr = 1; tick();
      for (int k = 1; k <= 17; k++) begin
         set_rf(5'(k % 31 + 1), 32'(k));
         tick();
      end
      chk("full_count0", ocnt[0], 16);
      chk("full_ovf0", oovf[0], 1);
      chk("full_count1", ocnt[1], 16);
      chk("full_ovf1", oovf[1], 1);
      for (int k = 0; k < 16; k++) begin
         chk("drain0", odata[0], 32'(k + 1));
         chk("drain1", odata[1], 32'(k + 2));
         idle(); ready = 1;
         tick();
      end

      // push and pop on a full FIFO
      idle(); clr = 1; tick();
      for (int k = 1; k <= 16; k++) begin
         set_rf(5'd7, 32'(k + 100));
         tick();
      end
      set_rf(5'd7, 32'h77); ready = 1; tick();
      chk("pp_count0", ocnt[0], 16);
      chk("pp_ovf0", oovf[0], 0);
      chk("pp_count1", ocnt[1], 16);
      chk("pp_ovf1", oovf[1], 0);

      // RF and DM in the same cycle
      idle(); clr = 1; tick();
      set_rf(5'd9, 32'hA5A5); dm_wen = 1; dm_addr = 32'h3000; dm_wd = 32'h1; tick();
      chk("col_count", ocnt[0], 1);
      chk("col_flag", ocol[0], 1);
      chk("col_kind", okind[0], 2'b01);

      // clear beats a concurrent push
      idle(); clr = 1; tick();
      for (int k = 1; k <= 8; k++) begin
         set_rf(5'd3, 32'(k)); tick();
      end
      set_rf(5'd3, 32'h99); clr = 1; tick();
      chk("clr_count", ocnt[0], 0);
      chk("clr_valid", ov[0], 0);
      chk("clr_col", ocol[0], 0);

      // mid-stream reset, timestamp restarts
      for (int k = 1; k <= 8; k++) begin
         set_rf(5'd4, 32'(k)); tick();
      end
      set_rf(5'd4, 32'h98); rst = 1; tick();
      chk("rst2_count", ocnt[0], 0);
      chk("rst2_valid", ov[0], 0);
      set_rf(5'd4, 32'h42); tick();
      chk("rst2_ts", ots[0], 0);
      set_rf(5'd4, 32'h43); tick();
      chk("rst2_ts_next", ots[0], 0);

      // randomized traffic
      rp = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) rp = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 50 : 90);
         en      = ($urandom_range(0, 9) != 0);
         rf_wen  = $urandom_range(0, 1) == 1;
         wnum    = 5'($urandom_range(0, 31));
         rf_wd   = $urandom;
         dm_wen  = $urandom_range(0, 3) == 0;
         dm_addr = $urandom;
         dm_wd   = $urandom;
         pc      = $urandom;
         ready   = ($urandom_range(0, 99) < rp);
         clr     = ($urandom_range(0, 199) == 0);
         rst     = ($urandom_range(0, 499) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
